// File: rtl/baw_pkg.sv
// Shared definitions for the Black-and-White board game front end and game FSM.
//   - Button index constants and count
//   - Per-channel debounce FSM state type
//   - Game FSM state encoding
//   - btn_prio_pick(): one-hot pick of the highest-priority pressed button
package baw_pkg;

  localparam int BTN_CENTER = 0;
  localparam int BTN_TOP    = 1;
  localparam int BTN_BOTTOM = 2;
  localparam int BTN_LEFT   = 3;
  localparam int BTN_RIGHT  = 4;
  localparam int BTN_COUNT  = 5;

  typedef enum logic {
    DB_STABLE,
    DB_CHANGING
  } db_state_t;

  typedef enum logic [2:0] {
    GS_INIT,
    GS_SELECT,
    GS_MOVE,
    GS_CHECK,
    GS_WIN_BLACK,
    GS_WIN_WHITE
  } game_state_t;

  // Priority bottom > center > top > left > right. Bottom is the
  // abort-to-init button, so it must never be lost in a collision.
  function automatic logic [BTN_COUNT-1:0] btn_prio_pick(input logic [BTN_COUNT-1:0] v);
    logic [BTN_COUNT-1:0] r;
    r = '0;
    if      (v[BTN_BOTTOM]) r[BTN_BOTTOM] = 1'b1;
    else if (v[BTN_CENTER]) r[BTN_CENTER] = 1'b1;
    else if (v[BTN_TOP])    r[BTN_TOP]    = 1'b1;
    else if (v[BTN_LEFT])   r[BTN_LEFT]   = 1'b1;
    else if (v[BTN_RIGHT])  r[BTN_RIGHT]  = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/baw_btn_debounce.sv
// Single button channel: synchroniser, debounce counter and FSM.
// Ports:
//   i_clk     system clock, rising edge
//   i_resetn  synchronous active-low reset
//   i_raw     raw asynchronous button input
//   o_level   debounced level (registered)
//   o_press   high when a 0->1 level change is accepted on the coming edge
module baw_btn_debounce
  import baw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_synced;
  db_state_t              r_state, w_state_nx;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nx;
  logic                   r_level, w_level_nx;
  logic                   w_press;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) r_sync <= '0;
    else           r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state <= DB_STABLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_level <= w_level_nx;
    end
  end

  // Entering CHANGING costs one edge with the counter still at 0, then the
  // counter runs 0..CNT_MAX; the level flips on the edge after CNT_MAX.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_level_nx = r_level;
    w_press    = 1'b0;
    case (r_state)
      DB_STABLE: begin
        w_cnt_nx = '0;
        if (w_synced != r_level) w_state_nx = DB_CHANGING;
      end
      DB_CHANGING: begin
        if (w_synced == r_level) begin
          w_state_nx = DB_STABLE;
          w_cnt_nx   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nx = DB_STABLE;
          w_cnt_nx   = '0;
          w_level_nx = ~r_level;
          w_press    = ~r_level;
        end else begin
          w_cnt_nx   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nx = DB_STABLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  assign o_level = r_level;
  assign o_press = w_press;

endmodule

// File: rtl/baw_button_conditioner.sv
// Button front end: five independent debounce channels feeding registered
// single-cycle press pulses to the game FSM.
// Ports:
//   i_clk            system clock, rising edge
//   i_resetn         synchronous active-low reset
//   i_btn_raw[4:0]   raw buttons (0 center, 1 top, 2 bottom, 3 left, 4 right)
//   o_btn_level      debounced levels
//   o_btn_pulse      one-cycle pulse per accepted press
//   o_btn_collision  one-cycle flag when several presses were accepted together
// Build option: BAW_BTN_ONEHOT_GUARD_EN keeps only the highest-priority press
// of a coincident group and raises o_btn_collision; otherwise every press
// passes through and o_btn_collision stays 0.
module baw_button_conditioner
  import baw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                 i_clk,
  input  logic                 i_resetn,
  input  logic [BTN_COUNT-1:0] i_btn_raw,
  output logic [BTN_COUNT-1:0] o_btn_level,
  output logic [BTN_COUNT-1:0] o_btn_pulse,
  output logic                 o_btn_collision
);

  logic [BTN_COUNT-1:0] w_press;
  logic [BTN_COUNT-1:0] w_pulse_nx;
  logic                 w_coll_nx;
  logic [BTN_COUNT-1:0] r_pulse;
  logic                 r_coll;

  baw_btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_db [BTN_COUNT-1:0] (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_raw    (i_btn_raw),
    .o_level  (o_btn_level),
    .o_press  (w_press)
  );

`ifdef BAW_BTN_ONEHOT_GUARD_EN
  logic w_multi;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign w_multi    = |(w_press & (w_press - BTN_COUNT'(1)));
  assign w_pulse_nx = w_multi ? btn_prio_pick(w_press) : w_press;
  assign w_coll_nx  = w_multi;
`else
  assign w_pulse_nx = w_press;
  assign w_coll_nx  = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_pulse <= '0;
      r_coll  <= 1'b0;
    end else begin
      r_pulse <= w_pulse_nx;
      r_coll  <= w_coll_nx;
    end
  end

  assign o_btn_pulse     = r_pulse;
  assign o_btn_collision = r_coll;

endmodule

// File: tb/tb_baw_button_conditioner.sv
module tb_baw_button_conditioner;
  import baw_pkg::*;

  localparam int D    = 4;
  localparam int S    = 2;
  localparam int NMAX = 8192;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [4:0] raw = 5'b0;
  logic [4:0] lvl, pls;
  logic       col;

  always #5 clk = ~clk;

  baw_button_conditioner #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
    .i_clk           (clk),
    .i_resetn        (resetn),
    .i_btn_raw       (raw),
    .o_btn_level     (lvl),
    .o_btn_pulse     (pls),
    .o_btn_collision (col)
  );

  int checks = 0;
  int errors = 0;
  int t = 0;

  // Reference history, one entry per rising edge.
  bit         rs_h [NMAX];
  logic [4:0] raw_h[NMAX];
  logic [4:0] sy_h [NMAX];
  logic [4:0] lv_h [NMAX];
  logic [4:0] m_pls;
  logic       m_col;

  typedef struct {
    logic       rn;
    logic [4:0] raw;
    int         hold;
    logic [4:0] lvl;
    logic [4:0] pls;
    logic       col;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rn, logic [4:0] r, int h, logic [4:0] el, logic [4:0] ep, logic ec);
    vec_t v;
    v.rn = rn; v.raw = r; v.hold = h; v.lvl = el; v.pls = ep; v.col = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, t, act, exp);
    end
  endtask

  // Behavioural rules: the synced value lags raw by the synchroniser depth
  // (forced 0 while reset touches the chain); a level flips once the last
  // D+1 synced samples all disagree with it; a 0->1 flip is a press.
  task automatic model_edge();
    logic       any;
    logic [4:0] prev, lv, press;
    int         n;
    any = 1'b0;
    for (int k = t - S + 1; k <= t; k++) if (k < 0 || rs_h[k]) any = 1'b1;
    if (any) sy_h[t] = 5'b0;
    else     sy_h[t] = raw_h[t-S+1];
    prev = 5'b0;
    if (t > 0) prev = lv_h[t-1];
    lv = prev;
    if (rs_h[t]) lv = 5'b0;
    else if (t >= D + 1) begin
      for (int ch = 0; ch < 5; ch++) begin
        bit flip;
        flip = 1'b1;
        for (int k = t - D - 1; k <= t - 1; k++) if (sy_h[k][ch] == prev[ch]) flip = 1'b0;
        if (flip) lv[ch] = ~prev[ch];
      end
    end
    lv_h[t] = lv;
    press = lv & ~prev;
    m_pls = press;
    m_col = 1'b0;
`ifdef BAW_BTN_ONEHOT_GUARD_EN
    n = $countones(press);
    if (n > 1) begin
      int ord[5];
      ord = '{BTN_BOTTOM, BTN_CENTER, BTN_TOP, BTN_LEFT, BTN_RIGHT};
      m_col = 1'b1;
      m_pls = 5'b0;
      for (int i = 4; i >= 0; i--) if (press[ord[i]]) begin
        m_pls = 5'b0;
        m_pls[ord[i]] = 1'b1;
      end
    end
`else
    n = 0;
`endif
  endtask

  task automatic step(input logic rn, input logic [4:0] r);
    if (t >= NMAX) begin
      $display("FAIL history_overflow cyc=%0d got=%0d want<%0d", t, t, NMAX);
      $fatal(1, "history overflow");
    end
    resetn = rn;
    raw    = r;
    @(posedge clk);
    rs_h[t]  = ~rn;
    raw_h[t] = r;
    model_edge();
    #1;
    chk("model_level", lvl, lv_h[t]);
    chk("model_pulse", pls, m_pls);
    chk("model_coll",  col, m_col);
    t++;
  endtask

  initial begin
    logic [4:0] p4;
    logic       c4;
    int         np;
    logic [4:0] rr;
    logic       rn;
`ifdef BAW_BTN_ONEHOT_GUARD_EN
    p4 = 5'b00100; c4 = 1'b1;
`else
    p4 = 5'b01100; c4 = 1'b0;
`endif
    // reset state, raw all high during reset
    vt.push_back(mk(0, 5'b11111, 2, 5'b0, 5'b0, 0));
    vt.push_back(mk(1, 5'b00000, 8, 5'b0, 5'b0, 0));
    // clean top press, 50-cycle hold, release without pulse
    vt.push_back(mk(1, 5'b00010, 6, 5'b00000, 5'b00000, 0));
    vt.push_back(mk(1, 5'b00010, 1, 5'b00010, 5'b00010, 0));
    vt.push_back(mk(1, 5'b00010, 1, 5'b00010, 5'b00000, 0));
    vt.push_back(mk(1, 5'b00010, 42, 5'b00010, 5'b00000, 0));
    vt.push_back(mk(1, 5'b00000, 6, 5'b00010, 5'b00000, 0));
    vt.push_back(mk(1, 5'b00000, 1, 5'b00000, 5'b00000, 0));
    vt.push_back(mk(1, 5'b00000, 4, 5'b00000, 5'b00000, 0));
    // center bounce 1,0,1,0 then steady
    vt.push_back(mk(1, 5'b00001, 1, 5'b0, 5'b0, 0));
    vt.push_back(mk(1, 5'b00000, 1, 5'b0, 5'b0, 0));
    vt.push_back(mk(1, 5'b00001, 1, 5'b0, 5'b0, 0));
    vt.push_back(mk(1, 5'b00000, 1, 5'b0, 5'b0, 0));
    vt.push_back(mk(1, 5'b00001, 6, 5'b00000, 5'b00000, 0));
    vt.push_back(mk(1, 5'b00001, 1, 5'b00001, 5'b00001, 0));
    vt.push_back(mk(1, 5'b00001, 1, 5'b00001, 5'b00000, 0));
    vt.push_back(mk(1, 5'b00000, 9, 5'b00000, 5'b00000, 0));
    // 3-cycle glitch on left
    vt.push_back(mk(1, 5'b01000, 3, 5'b0, 5'b0, 0));
    vt.push_back(mk(1, 5'b00000, 8, 5'b0, 5'b0, 0));
    // bottom + left together
    vt.push_back(mk(1, 5'b01100, 6, 5'b00000, 5'b00000, 0));
    vt.push_back(mk(1, 5'b01100, 1, 5'b01100, p4, c4));
    vt.push_back(mk(1, 5'b01100, 1, 5'b01100, 5'b00000, 0));
    vt.push_back(mk(1, 5'b00000, 9, 5'b00000, 5'b00000, 0));
    // reset 3 cycles into right's debounce
    vt.push_back(mk(1, 5'b10000, 3, 5'b0, 5'b0, 0));
    vt.push_back(mk(0, 5'b10000, 2, 5'b0, 5'b0, 0));
    vt.push_back(mk(1, 5'b10000, 6, 5'b00000, 5'b00000, 0));
    vt.push_back(mk(1, 5'b10000, 1, 5'b10000, 5'b10000, 0));
    vt.push_back(mk(1, 5'b00000, 7, 5'b00000, 5'b00000, 0));
    // reset lands on the edge where right would have qualified
    vt.push_back(mk(1, 5'b10000, 6, 5'b00000, 5'b00000, 0));
    vt.push_back(mk(0, 5'b10000, 1, 5'b00000, 5'b00000, 0));
    vt.push_back(mk(1, 5'b10000, 6, 5'b00000, 5'b00000, 0));
    vt.push_back(mk(1, 5'b10000, 1, 5'b10000, 5'b10000, 0));
    vt.push_back(mk(1, 5'b00000, 7, 5'b00000, 5'b00000, 0));

    for (int i = 0; i < vt.size(); i++) begin
      for (int h = 0; h < vt[i].hold; h++) step(vt[i].rn, vt[i].raw);
      chk($sformatf("vec%0d_level", i), lvl, vt[i].lvl);
      chk($sformatf("vec%0d_pulse", i), pls, vt[i].pls);
      chk($sformatf("vec%0d_coll",  i), col, vt[i].col);
    end

    // right held 1000 cycles: exactly one pulse
    np = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 5'b10000);
      np += $countones(pls);
    end
    chk("hold1000_pulses", np, 1);
    chk("hold1000_level", lvl, 5'b10000);
    for (int i = 0; i < 8; i++) step(1'b1, 5'b00000);
    chk("hold1000_release", lvl, 5'b00000);

    // random traffic; whole-vector changes give coincident presses
    rr = 5'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) rr = 5'($urandom_range(0, 31));
      rn = ($urandom_range(0, 399) != 0);
      step(rn, rr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
